// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW = 6;
  localparam int unsigned DefDataW = 32;

  // Port identifiers used for owner / last_grant encoding.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin tie-break: a lone requester wins, a tie goes to
// the port that did not win last time.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant
);

  // Pick the winner; with no requests the output is a don't-care, held at PORT_I.
  always_comb begin
    grant = PORT_I;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-cache read port and a data-cache read/write port
// onto a single shared memory, one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clock,
  input  logic              reset,
  // Port 0: instruction cache (read only)
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  // Port 1: data cache
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  // Shared memory
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  // Command is latched at grant so a withdrawn request still completes.
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req, grant, mem_active;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  rr_arbiter2 u_rr_arbiter2 (
    .req0       (i_req),
    .req1       (d_req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // State and latched-command registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_D;
      data_q       <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next-state: arbitrate in idle, then issue, wait for memory, and release.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          state_d      = StIssue;
          owner_d      = grant;
          last_grant_d = grant;
          if (grant == PORT_D) begin
            // Read+write together is treated as a write.
            wr_d    = d_write;
            addr_d  = d_address;
            wdata_d = d_write ? d_writedata : '0;
          end else begin
            wr_d    = 1'b0;
            addr_d  = i_address;
            wdata_d = '0;
          end
        end
      end
      StIssue: begin
        if (mem_busywait) state_d = StWait;
      end
      StWait: begin
        if (!mem_busywait) begin
          state_d = StDone;
          data_d  = mem_readdata;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Memory outputs are forced to zero outside the issue/wait window.
  always_comb begin
    mem_active    = (state_q == StIssue) || (state_q == StWait);
    mem_read      = mem_active & ~wr_q;
    mem_write     = mem_active & wr_q;
    mem_address   = mem_active ? addr_q : '0;
    mem_writedata = mem_active ? wdata_q : '0;
  end

  // Stall each requester except in its own done cycle.
  always_comb begin
    i_busywait = i_req & ~((state_q == StDone) && (owner_q == PORT_I));
    d_busywait = d_req & ~((state_q == StDone) && (owner_q == PORT_D));
    i_readdata = data_q;
    d_readdata = data_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-busy-cycle memory model.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read, d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_writedata;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  int checks;
  int errors;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Memory model: busy for 4 cycles per access, then idle until the command drops.
  logic [DW-1:0] mem [64];
  int            busy_cnt;
  logic          hold;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wdata;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 64; k++) mem[k] <= DW'(k);
      mem[5]       <= 32'hDEADBEEF;
      mem[17]      <= 32'hCAFEF00D;
      mem_busywait <= 1'b0;
      mem_readdata <= '0;
      busy_cnt     <= 0;
      hold         <= 1'b0;
      m_addr       <= '0;
      m_wr         <= 1'b0;
      m_wdata      <= '0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        mem_busywait <= 1'b0;
        hold         <= 1'b1;
        if (m_wr) mem[m_addr] <= m_wdata;
        else      mem_readdata <= mem[m_addr];
      end
    end else if (hold) begin
      if (!mem_read && !mem_write) hold <= 1'b0;
    end else if (mem_read || mem_write) begin
      mem_busywait <= 1'b1;
      busy_cnt     <= 4;
      m_addr       <= mem_address;
      m_wr         <= mem_write;
      m_wdata      <= mem_writedata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Negedges until a memory command appears (-1 on timeout).
  task automatic wait_issue(output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (mem_read || mem_write) begin
        n = k;
        break;
      end
    end
  endtask

  // Negedges until a requesting port sees its stall drop; returns that port.
  task automatic wait_release(output int port, output int n);
    port = -1;
    n    = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (i_read && !i_busywait) begin
        port = 0;
        n    = k;
        break;
      end
      if ((d_read || d_write) && !d_busywait) begin
        port = 1;
        n    = k;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int p, n;
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    i_read      = 1'b0;
    i_address   = '0;
    d_read      = 1'b0;
    d_write     = 1'b0;
    d_address   = '0;
    d_writedata = '0;

    // Reset state, with a request held during reset
    repeat (2) @(negedge clock);
    i_read = 1'b1;
    #1;
    check("rst_mem_read", {31'b0, mem_read}, 0);
    check("rst_mem_write", {31'b0, mem_write}, 0);
    check("rst_mem_address", {26'b0, mem_address}, 0);
    check("rst_mem_writedata", mem_writedata, 0);
    check("rst_i_readdata", i_readdata, 0);
    check("rst_i_busywait", {31'b0, i_busywait}, 1);
    i_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Single instruction read
    i_read    = 1'b1;
    i_address = 6'h05;
    wait_release(p, n);
    check("t1_port", p, 0);
    check("t1_latency", n, 7);
    check("t1_i_readdata", i_readdata, 32'hDEADBEEF);
    check("t1_d_busywait", {31'b0, d_busywait}, 0);
    check("t1_done_mem_read", {31'b0, mem_read}, 0);
    i_read = 1'b0;
    @(negedge clock);

    // Data write held from issue through wait
    d_write     = 1'b1;
    d_address   = 6'h2A;
    d_writedata = 32'h12345678;
    wait_issue(n);
    check("t2_issue_delay", n, 1);
    check("t2_mem_write", {31'b0, mem_write}, 1);
    check("t2_mem_read", {31'b0, mem_read}, 0);
    check("t2_mem_address", {26'b0, mem_address}, 32'h2A);
    check("t2_mem_writedata", mem_writedata, 32'h12345678);
    repeat (3) @(negedge clock);
    check("t2_hold_write", {31'b0, mem_write}, 1);
    check("t2_hold_address", {26'b0, mem_address}, 32'h2A);
    check("t2_hold_writedata", mem_writedata, 32'h12345678);
    wait_release(p, n);
    check("t2_port", p, 1);
    d_write = 1'b0;
    @(negedge clock);

    // Simultaneous requests after reset: port 0 first, port 1 after one idle cycle
    pulse_reset();
    i_read    = 1'b1;
    i_address = 6'h05;
    d_read    = 1'b1;
    d_address = 6'h11;
    wait_release(p, n);
    check("t3_first_port", p, 0);
    check("t3_first_latency", n, 7);
    check("t3_d_busy_at_first", {31'b0, d_busywait}, 1);
    i_read = 1'b0;
    wait_release(p, n);
    check("t3_second_port", p, 1);
    check("t3_second_spacing", n, 8);
    check("t3_d_readdata", d_readdata, 32'hCAFEF00D);
    d_read = 1'b0;
    @(negedge clock);

    // Continuous contention alternates grants
    pulse_reset();
    check("t4_data_reset", i_readdata, 0);
    i_read    = 1'b1;
    i_address = 6'h05;
    d_read    = 1'b1;
    d_address = 6'h11;
    for (int k = 0; k < 4; k++) begin
      wait_release(p, n);
      check($sformatf("t4_grant%0d", k), p, k % 2);
    end
    i_read = 1'b0;
    d_read = 1'b0;
    @(negedge clock);

    // Reset during wait abandons the access; request re-arbitrated afterwards
    i_read    = 1'b1;
    i_address = 6'h05;
    repeat (3) @(negedge clock);
    check("t5_in_wait_read", {31'b0, mem_read}, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_mem_read", {31'b0, mem_read}, 0);
    check("t5_rst_mem_address", {26'b0, mem_address}, 0);
    check("t5_rst_i_busywait", {31'b0, i_busywait}, 1);
    check("t5_rst_data", i_readdata, 0);
    @(negedge clock);
    reset = 1'b1;
    wait_release(p, n);
    check("t5_rearb_port", p, 0);
    check("t5_rearb_latency", n, 7);
    i_read = 1'b0;
    @(negedge clock);

    // Read and write together is a write
    d_read      = 1'b1;
    d_write     = 1'b1;
    d_address   = 6'h33;
    d_writedata = 32'h0BADF00D;
    wait_issue(n);
    check("t6_mem_write", {31'b0, mem_write}, 1);
    check("t6_mem_read", {31'b0, mem_read}, 0);
    wait_release(p, n);
    check("t6_port", p, 1);
    d_write = 1'b0;
    @(negedge clock);
    wait_release(p, n);
    check("t6_readback", d_readdata, 32'h0BADF00D);
    d_read = 1'b0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the memory block-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the memory block-data width.
REQ-003 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 i_read  in  1  SHALL be the instruction-cache read request (port 0, read-only).
REQ-006 i_address  in  ADDR_W  SHALL be the port-0 block address.
REQ-007 i_readdata  out  DATA_W  SHALL be the port-0 returned block.
REQ-008 i_busywait  out  1  SHALL be the port-0 stall.
REQ-009 d_read, d_write  in  1 each  SHALL be the data-cache read and write requests (port 1).
REQ-010 d_address  in  ADDR_W  SHALL be the port-1 block address.
REQ-011 d_writedata  in  DATA_W  SHALL be the port-1 write block.
REQ-012 d_readdata  out  DATA_W  SHALL be the port-1 returned block.
REQ-013 d_busywait  out  1  SHALL be the port-1 stall.
REQ-014 mem_read, mem_write  out  1 each  SHALL be the shared memory commands.
REQ-015 mem_address  out  ADDR_W  SHALL be the memory block address.
REQ-016 mem_writedata  out  DATA_W  SHALL be the memory write block.
REQ-017 mem_readdata  in  DATA_W  SHALL be the memory read block.
REQ-018 mem_busywait  in  1  SHALL be the memory busy flag.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE, plus an owner register (0/1) and a last_grant register.
REQ-020 IDLE: if any request is active at a rising edge, the FSM SHALL move to ISSUE with owner chosen round-robin; otherwise it stays in IDLE.
REQ-021 Round-robin: a single requester wins; on a tie, the port not equal to last_grant wins; last_grant SHALL update when leaving IDLE.
REQ-022 ISSUE: the FSM SHALL drive the owner's command, address and writedata to memory, and move to WAIT on the first edge with mem_busywait=1.
REQ-023 WAIT: the FSM SHALL hold the memory command, and on the first edge with mem_busywait=0 move to DONE, capturing mem_readdata into data_q.
REQ-024 DONE: lasts exactly 1 cycle with mem_read=mem_write=0, then the FSM SHALL go to IDLE.
REQ-025 x_busywait SHALL equal (x request active) AND NOT (state==DONE AND owner==x), combinationally.
REQ-026 i_readdata and d_readdata SHALL both equal data_q; the value is valid only in the owner's DONE cycle.
REQ-027 Outside ISSUE/WAIT, mem_read, mem_write, mem_address and mem_writedata SHALL be 0 (never X).
REQ-028 If d_read and d_write are both high, the arbiter SHALL treat the request as a write.
REQ-029 A request withdrawn after grant SHALL NOT abort the transaction; the FSM SHALL complete it to DONE.
REQ-030 The non-owner's busywait SHALL stay high throughout another port's transaction, and it SHALL be serviced in the next IDLE arbitration.
REQ-031 Minimum request-to-release latency SHALL be 3 edges plus memory busy cycles; back-to-back transactions SHALL have one IDLE cycle between DONE and the next ISSUE.

Reset
REQ-032 When reset is low, the block SHALL asynchronously set state=IDLE, owner=0, last_grant=1, data_q=0, and all memory outputs to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction; busywaits SHALL then follow REQ-025 from IDLE.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state encoding, the port-ID constants (PORT_I=0, PORT_D=1) and the default ADDR_W/DATA_W.
REQ-035 The tie-break logic SHALL live in sub-module rr_arbiter2 (two requests plus last_grant in, grant index out, combinational).

Verification
REQ-036 Verification SHALL use a memory model with 4 busy cycles and cover:
- i_read, i_address=6'h05, memory returns 32'hDEADBEEF -> DONE with i_busywait=0 for 1 cycle and i_readdata=32'hDEADBEEF; d_busywait unaffected (0).
- d_write, d_address=6'h2A, d_writedata=32'h12345678 -> mem_write=1, mem_address=6'h2A, mem_writedata=32'h12345678 held ISSUE..WAIT; mem_read=0.
- i_read and d_read rise in the same cycle after reset -> port 0 is served first, then port 1; d_busywait stays high until the second DONE.
- Both ports request continuously for 4 transactions -> grants alternate 0,1,0,1.
- reset pulled low during WAIT -> all memory outputs are 0 immediately, state=IDLE, and the pending request is re-arbitrated after release.
- d_read and d_write both high -> mem_write=1, mem_read=0.
